// File: rtl/sonar_display_pkg.sv
// Shared display definitions: hex glyph table, blank pattern and scan-reader FSM states.
// Glyphs are {g,f,e,d,c,b,a}, active-low, indexed by the hex value they display.
package sonar_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic {
        SETTLING,
        HELD
    } scan_state_e;

endpackage

// File: rtl/seven_segment_scan_reader_if.sv
// Pin-side and readback signals of the seven-segment scan reader.
// master drives the scanned display pins; slave is the reader itself.
interface seven_segment_scan_reader_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    clear;
    logic [4*NUM_DIGITS-1:0] value_out;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    frame_done;
    logic                    err_illegal;

    modport master (
        output seg_in,
        output dig_sel,
        output clear,
        input  value_out,
        input  digit_valid,
        input  frame_done,
        input  err_illegal
    );

    modport slave (
        input  seg_in,
        input  dig_sel,
        input  clear,
        output value_out,
        output digit_valid,
        output frame_done,
        output err_illegal
    );
endinterface

// File: rtl/seven_segment_pattern_encoder.sv
// Combinational inverse of the hex glyph table: classifies a segment pattern
// as a hex glyph (with its nibble), the blank pattern, or neither.
module seven_segment_pattern_encoder
    import sonar_display_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       is_hex,
    output logic       is_blank,
    output logic [3:0] nibble
);

    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == HEX_GLYPH[i]) begin
                is_hex = 1'b1;
                nibble = 4'(i);
            end
        end
    end

    assign is_blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seven_segment_scan_reader.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus. A digit pattern
// must stay unchanged for STABLE_CYCLES samples before it is committed to the readback.
module seven_segment_scan_reader
    import sonar_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    seven_segment_scan_reader_if.slave bus
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    logic [6:0]              seg_meta, seg_smp, seg_prev;
    logic [NUM_DIGITS-1:0]   sel_meta, sel_smp, sel_prev;
    logic                    changed;
    logic [7:0]              cnt_q, cnt_d;
    scan_state_e             state_q, state_d;
    logic                    commit;
    logic                    sel_onehot;
    logic                    enc_hex, enc_blank;
    logic [3:0]              enc_nibble;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    err_stage_q, err_stage_d;
    logic                    frame_stage_q, frame_stage_d;
    logic                    err_q, frame_q;

    // Pins are asynchronous to clk; only the second stage (the sample) is used.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_meta <= SEG_BLANK;
            seg_smp  <= SEG_BLANK;
            seg_prev <= SEG_BLANK;
            sel_meta <= '0;
            sel_smp  <= '0;
            sel_prev <= '0;
        end else begin
            seg_meta <= bus.seg_in;
            seg_smp  <= seg_meta;
            seg_prev <= seg_smp;
            sel_meta <= bus.dig_sel;
            sel_smp  <= sel_meta;
            sel_prev <= sel_smp;
        end
    end

    assign changed    = (seg_smp != seg_prev) || (sel_smp != sel_prev);
    assign sel_onehot = ($countones(sel_smp) == 1);

    always_comb begin
        cnt_d = cnt_q;
        if (changed) begin
            cnt_d = 8'd1;
        end else if (cnt_q < STABLE_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (bus.clear) begin
            cnt_d = '0;
        end
    end

    // Commit fires on the edge where the counter reaches its target, so a pattern is
    // committed once per stable run; HELD waits for the next change.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            SETTLING: begin
                if (cnt_d == STABLE_MAX) begin
                    state_d = HELD;
                    commit  = 1'b1;
                end
            end
            HELD: begin
                if (changed) begin
                    state_d = SETTLING;
                end
            end
            default: state_d = SETTLING;
        endcase
        if (bus.clear) begin
            state_d = SETTLING;
            commit  = 1'b0;
        end
    end

    seven_segment_pattern_encoder u_encoder (
        .pattern  (seg_smp),
        .is_hex   (enc_hex),
        .is_blank (enc_blank),
        .nibble   (enc_nibble)
    );

    // Blanking (no select) and ghosting (several selects) commit nothing.
    always_comb begin
        value_d       = value_q;
        valid_d       = valid_q;
        seen_d        = seen_q;
        err_stage_d   = 1'b0;
        frame_stage_d = 1'b0;
        if (commit && sel_onehot) begin
            seen_d = seen_q | sel_smp;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_smp[i]) begin
                    valid_d[i] = enc_hex;
                    if (enc_hex) begin
                        value_d[4*i +: 4] = enc_nibble;
                    end
                end
            end
            err_stage_d = !enc_hex && !enc_blank;
            if (&seen_d) begin
                frame_stage_d = 1'b1;
                seen_d        = '0;
            end
        end
        if (bus.clear) begin
            value_d       = '0;
            valid_d       = '0;
            seen_d        = '0;
            err_stage_d   = 1'b0;
            frame_stage_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            state_q       <= SETTLING;
            value_q       <= '0;
            valid_q       <= '0;
            seen_q        <= '0;
            err_stage_q   <= 1'b0;
            frame_stage_q <= 1'b0;
            err_q         <= 1'b0;
            frame_q       <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            value_q       <= value_d;
            valid_q       <= valid_d;
            seen_q        <= seen_d;
            err_stage_q   <= err_stage_d;
            frame_stage_q <= frame_stage_d;
            // Pulses trail the readback update by one cycle; clear squashes them.
            err_q         <= err_stage_q & ~bus.clear;
            frame_q       <= frame_stage_q & ~bus.clear;
        end
    end

    assign bus.value_out   = value_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_done  = frame_q;
    assign bus.err_illegal = err_q;

endmodule

// File: tb/tb_seven_segment_scan_reader.sv
// Bench for seven_segment_scan_reader: directed scenarios plus randomized scanning
// checked against a timestamp-based reference model of the settle/commit rules.
module tb_seven_segment_scan_reader;

    localparam int unsigned ND = 4;
    localparam int unsigned SC = 8;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seven_segment_scan_reader_if #(.NUM_DIGITS(ND)) bus ();

    seven_segment_scan_reader #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int n_err;
    int n_frame;

    // Reference model: pins captured at each edge are kept in a short history; a pattern
    // commits when the sample has been unchanged (or clear/reset released) for SC edges.
    logic [ND+6:0]   hist [$];
    int              edge_n;
    int              settle_start;
    bit              committed;
    logic [4*ND-1:0] m_value;
    logic [ND-1:0]   m_valid, m_seen;
    logic            m_frame, m_err;
    bit              frame_nxt, err_nxt;

    task automatic model_init();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back({{ND{1'b0}}, 7'h7F});
        edge_n       = 0;
        settle_start = 1;
        committed    = 0;
        m_value      = '0;
        m_valid      = '0;
        m_seen       = '0;
        m_frame      = 1'b0;
        m_err        = 1'b0;
        frame_nxt    = 0;
        err_nxt      = 0;
    endtask

    task automatic model_step();
        logic [ND+6:0] smp, prv;
        logic [ND-1:0] sel;
        logic [6:0]    seg;
        bit            hit;
        edge_n++;
        hist.push_back({bus.dig_sel, bus.seg_in});
        if (hist.size() > 4) hist.delete(0);
        smp = hist[1];
        prv = hist[0];
        m_frame = frame_nxt;
        m_err   = err_nxt;
        frame_nxt = 0;
        err_nxt   = 0;
        if (bus.clear === 1'b1) begin
            m_value = '0;
            m_valid = '0;
            m_seen  = '0;
            m_frame = 1'b0;
            m_err   = 1'b0;
            settle_start = edge_n + 1;
            committed    = 0;
        end else begin
            if (smp != prv) begin
                settle_start = edge_n;
                committed    = 0;
            end
            if (!committed && (edge_n - settle_start + 1 == int'(SC))) begin
                committed = 1;
                sel = smp[ND+6:7];
                seg = smp[6:0];
                if ($countones(sel) == 1) begin
                    for (int i = 0; i < int'(ND); i++) begin
                        if (sel[i]) begin
                            m_seen[i] = 1'b1;
                            hit = 0;
                            for (int g = 0; g < 16; g++) begin
                                if (GLYPH[g] == seg) begin
                                    hit = 1;
                                    m_value[4*i +: 4] = 4'(g);
                                end
                            end
                            m_valid[i] = hit;
                            if (!hit && seg != 7'h7F) err_nxt = 1;
                        end
                    end
                    if (&m_seen) begin
                        frame_nxt = 1;
                        m_seen    = '0;
                    end
                end
            end
        end
    endtask

    initial begin
        model_init();
        forever begin
            @(posedge clk or posedge reset);
            if (reset === 1'b1) model_init();
            else model_step();
        end
    end

    // Stimulus helpers; every task starts and ends just after a falling edge.
    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.err_illegal === 1'b1) n_err++;
            if (bus.frame_done === 1'b1) n_frame++;
        end
    endtask

    task automatic hold(input logic [ND-1:0] sel, input logic [6:0] seg, input int n);
        bus.dig_sel = sel;
        bus.seg_in  = seg;
        cycles(n);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        cycles(1);
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (bus.value_out !== 16'h0 || bus.digit_valid !== 4'h0 ||
            bus.frame_done !== 1'b0 || bus.err_illegal !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got %h/%b/%b/%b, expected 0000/0000/0/0",
                     bus.value_out, bus.digit_valid, bus.frame_done, bus.err_illegal);
        end
        reset = 1'b0;
        hold(4'b0100, GLYPH[2], SC + 4);
        tests++;
        if (bus.value_out !== 16'h0200 || bus.digit_valid !== 4'b0100) begin
            fails++;
            $display("FAIL reset_precommit: got %h/%b, expected 0200/0100",
                     bus.value_out, bus.digit_valid);
        end
        hold(4'b0100, GLYPH[5], 4);
        #2 reset = 1'b1;
        #1;
        tests++;
        if (bus.value_out !== 16'h0 || bus.digit_valid !== 4'h0 ||
            bus.frame_done !== 1'b0 || bus.err_illegal !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: got %h/%b/%b/%b, expected 0000/0000/0/0",
                     bus.value_out, bus.digit_valid, bus.frame_done, bus.err_illegal);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_err = 0;
        n_frame = 0;
        cycles(SC + 6);
        tests++;
        if (n_err !== 0 || n_frame !== 0) begin
            fails++;
            $display("FAIL reset_no_pulse: got err=%0d frame=%0d, expected 0/0", n_err, n_frame);
        end
        tests++;
        if (bus.value_out !== 16'h0500 || bus.digit_valid !== 4'b0100) begin
            fails++;
            $display("FAIL reset_recommit: got %h/%b, expected 0500/0100",
                     bus.value_out, bus.digit_valid);
        end
    endtask

    task automatic test_single_commit();
        do_clear();
        n_err = 0;
        n_frame = 0;
        bus.dig_sel = 4'b0001;
        bus.seg_in  = GLYPH[3];
        // k = 1 is the capture edge; the update is due on edge SC+2.
        for (int k = 1; k <= int'(SC) + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == int'(SC) + 1) begin
                tests++;
                if (bus.value_out !== 16'h0 || bus.digit_valid !== 4'h0) begin
                    fails++;
                    $display("FAIL single_early: got %h/%b at edge %0d, expected 0000/0000",
                             bus.value_out, bus.digit_valid, k);
                end
            end
            if (k == int'(SC) + 2) begin
                tests++;
                if (bus.value_out !== 16'h0003 || bus.digit_valid !== 4'b0001) begin
                    fails++;
                    $display("FAIL single_commit: got %h/%b at edge %0d, expected 0003/0001",
                             bus.value_out, bus.digit_valid, k);
                end
            end
        end
        cycles(4);
        tests++;
        if (n_err !== 0 || n_frame !== 0) begin
            fails++;
            $display("FAIL single_pulses: got err=%0d frame=%0d, expected 0/0", n_err, n_frame);
        end
    endtask

    task automatic test_glitch();
        do_clear();
        bus.dig_sel = 4'b0010;
        bus.seg_in  = GLYPH[7];
        cycles(5);
        bus.seg_in = GLYPH[8];
        cycles(1);
        bus.seg_in = GLYPH[7];
        for (int k = 1; k <= int'(SC) + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == int'(SC) + 1) begin
                tests++;
                if (bus.value_out !== 16'h0 || bus.digit_valid !== 4'h0) begin
                    fails++;
                    $display("FAIL glitch_early: got %h/%b at edge %0d, expected 0000/0000",
                             bus.value_out, bus.digit_valid, k);
                end
            end
            if (k == int'(SC) + 2) begin
                tests++;
                if (bus.value_out !== 16'h0070 || bus.digit_valid !== 4'b0010) begin
                    fails++;
                    $display("FAIL glitch_commit: got %h/%b at edge %0d, expected 0070/0010",
                             bus.value_out, bus.digit_valid, k);
                end
            end
        end
    endtask

    task automatic test_illegal_blank();
        do_clear();
        hold(4'b0010, GLYPH[9], SC + 4);
        tests++;
        if (bus.value_out !== 16'h0090 || bus.digit_valid !== 4'b0010) begin
            fails++;
            $display("FAIL illegal_setup: got %h/%b, expected 0090/0010",
                     bus.value_out, bus.digit_valid);
        end
        n_err = 0;
        hold(4'b0010, 7'b0110110, SC + 4);
        tests++;
        if (bus.value_out !== 16'h0090 || bus.digit_valid !== 4'b0000 || n_err !== 1) begin
            fails++;
            $display("FAIL illegal_pattern: got %h/%b err=%0d, expected 0090/0000 err=1",
                     bus.value_out, bus.digit_valid, n_err);
        end
        hold(4'b0010, GLYPH[9], SC + 4);
        n_err = 0;
        hold(4'b0010, 7'h7F, SC + 4);
        tests++;
        if (bus.value_out !== 16'h0090 || bus.digit_valid !== 4'b0000 || n_err !== 0) begin
            fails++;
            $display("FAIL blank_pattern: got %h/%b err=%0d, expected 0090/0000 err=0",
                     bus.value_out, bus.digit_valid, n_err);
        end
    endtask

    task automatic test_full_frame();
        int digs [4] = '{1, 10, 11, 15};
        do_clear();
        n_err = 0;
        n_frame = 0;
        for (int d = 0; d < 4; d++) begin
            hold(4'b0001 << d, GLYPH[digs[d]], SC + 4);
            hold(4'b0000, 7'h7F, 3);
        end
        tests++;
        if (bus.value_out !== 16'hFBA1 || bus.digit_valid !== 4'b1111) begin
            fails++;
            $display("FAIL frame_value: got %h/%b, expected FBA1/1111",
                     bus.value_out, bus.digit_valid);
        end
        tests++;
        if (n_frame !== 1 || n_err !== 0) begin
            fails++;
            $display("FAIL frame_pulse: got frame=%0d err=%0d, expected 1/0", n_frame, n_err);
        end
        n_frame = 0;
        hold(4'b0011, GLYPH[5], SC + 4);
        tests++;
        if (bus.value_out !== 16'hFBA1 || bus.digit_valid !== 4'b1111 ||
            n_frame !== 0 || n_err !== 0) begin
            fails++;
            $display("FAIL frame_multisel: got %h/%b frame=%0d err=%0d, expected FBA1/1111 0/0",
                     bus.value_out, bus.digit_valid, n_frame, n_err);
        end
    endtask

    task automatic test_clear_on_commit();
        do_clear();
        for (int d = 0; d < 3; d++) begin
            hold(4'b0001 << d, GLYPH[d + 4], SC + 4);
            hold(4'b0000, 7'h7F, 3);
        end
        n_err = 0;
        n_frame = 0;
        bus.dig_sel = 4'b1000;
        bus.seg_in  = GLYPH[12];
        cycles(SC + 1);
        bus.clear = 1'b1;
        cycles(1);
        bus.clear = 1'b0;
        tests++;
        if (bus.value_out !== 16'h0 || bus.digit_valid !== 4'h0) begin
            fails++;
            $display("FAIL clear_commit: got %h/%b, expected 0000/0000",
                     bus.value_out, bus.digit_valid);
        end
        cycles(SC + 6);
        tests++;
        if (n_frame !== 0 || n_err !== 0) begin
            fails++;
            $display("FAIL clear_pulses: got frame=%0d err=%0d, expected 0/0", n_frame, n_err);
        end
        tests++;
        if (bus.value_out !== 16'hC000 || bus.digit_valid !== 4'b1000) begin
            fails++;
            $display("FAIL clear_recommit: got %h/%b, expected C000/1000",
                     bus.value_out, bus.digit_valid);
        end
    endtask

    task automatic test_random();
        logic [ND-1:0] sel;
        logic [6:0]    seg;
        int            len;
        int            clr_at;
        for (int s = 0; s < 80; s++) begin
            case ($urandom_range(0, 9))
                0:       sel = 4'b0000;
                1:       sel = 4'b0011 << $urandom_range(0, 2);
                default: sel = 4'b0001 << $urandom_range(0, ND - 1);
            endcase
            case ($urandom_range(0, 7))
                0:       seg = 7'h7F;
                1:       seg = 7'($urandom);
                default: seg = GLYPH[$urandom_range(0, 15)];
            endcase
            len    = $urandom_range(1, SC + 6);
            clr_at = ($urandom_range(0, 14) == 0) ? $urandom_range(0, len - 1) : -1;
            bus.dig_sel = sel;
            bus.seg_in  = seg;
            for (int c = 0; c < len; c++) begin
                bus.clear = (c == clr_at);
                @(posedge clk);
                @(negedge clk);
                tests++;
                if (bus.value_out !== m_value) begin
                    fails++;
                    $display("FAIL rand_value edge %0d: got %h, expected %h",
                             edge_n, bus.value_out, m_value);
                end
                tests++;
                if (bus.digit_valid !== m_valid) begin
                    fails++;
                    $display("FAIL rand_valid edge %0d: got %b, expected %b",
                             edge_n, bus.digit_valid, m_valid);
                end
                tests++;
                if (bus.frame_done !== m_frame) begin
                    fails++;
                    $display("FAIL rand_frame edge %0d: got %b, expected %b",
                             edge_n, bus.frame_done, m_frame);
                end
                tests++;
                if (bus.err_illegal !== m_err) begin
                    fails++;
                    $display("FAIL rand_err edge %0d: got %b, expected %b",
                             edge_n, bus.err_illegal, m_err);
                end
            end
            bus.clear = 1'b0;
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.clear   = 1'b0;
        bus.seg_in  = 7'h7F;
        bus.dig_sel = '0;
        n_err       = 0;
        n_frame     = 0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single_commit();
        test_glitch();
        test_illegal_blank();
        test_full_frame();
        test_clear_on_commit();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seven_segment_scan_reader.md
Name: seven_segment_scan_reader

Overview:
Reverse direction of the hex-to-segment decoders in the SONAR display path. The block samples a multiplexed, active-low seven-segment bus {g,f,e,d,c,b,a} plus one-hot digit-select lines, and waits for each digit pattern to settle. It then converts each settled pattern back to its 4-bit hex value and holds a packed per-digit readback. It is used for display self-check and for capturing external instrument displays into the SONAR logic.

Parameters:
NUM_DIGITS, 4, number of scanned digits (1..8)
STABLE_CYCLES, 8, consecutive identical synchronized samples required before commit (2..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
seg_in  in  7  segment lines {g,f,e,d,c,b,a}, active-low, asynchronous to clk
dig_sel  in  NUM_DIGITS  digit enables, active-high, one-hot when a digit is driven
clear  in  1  synchronous clear of captured data
value_out  out  4*NUM_DIGITS  packed hex readback; digit i occupies [4i+3:4i]
digit_valid  out  NUM_DIGITS  1 = digit i holds a legal hex glyph
frame_done  out  1  one-cycle pulse when every digit has been committed since the last pulse
err_illegal  out  1  one-cycle pulse when a non-hex, non-blank pattern is committed

Behaviour:
- Reset and clock: one clock domain. reset is asynchronous and active-high.
- Reset values:
  - value_out = 0, digit_valid = 0, frame_done = 0, err_illegal = 0.
  - Sync stages: seg = 7'h7F, sel = 0.
  - Stability counter = 0, seen mask = 0, FSM in SETTLING.
- Input synchronization: seg_in and dig_sel each pass through a 2-flop synchronizer. All further logic uses the second stage, called the "sample".
- Stability tracking:
  - A prev register holds the last sample.
  - sample == prev (both seg and sel): counter increments, saturating at STABLE_CYCLES.
  - sample != prev: counter resets to 1.
- FSM states:
  - SETTLING: when the counter reaches STABLE_CYCLES, go to HELD and perform a commit on that same edge.
  - HELD: no further commits. Any change of the sample returns the FSM to SETTLING with counter = 1.
- Commit rules:
  - If sel is not one-hot (all zero = blanking interval, or multiple bits set), nothing updates and no pulses fire. The FSM still enters HELD.
  - Otherwise, the selected index i is added to the seen mask. The pattern is then handled by one of the three cases below.
- Legal hex pattern: value_out[i] gets the nibble and digit_valid[i] = 1. The encoding is the exact inverse of the team hex glyph table ({g..a}, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Blank pattern 1111111: digit_valid[i] = 0, value nibble retained, no error.
- Any other pattern: digit_valid[i] = 0, value nibble retained, err_illegal pulses on the cycle after the commit edge.
- frame_done: when the seen mask becomes all-ones, frame_done pulses for one cycle and the seen mask clears on the same edge.
- Latency: from the first clk edge on which a stable pin change is captured to the value_out update is STABLE_CYCLES+2 edges. Pulse outputs lag the value update by one cycle (registered).
- clear:
  - Zeroes value_out, digit_valid, the seen mask and the counter, and forces the FSM to SETTLING.
  - Has priority over a commit in the same cycle and suppresses pulses from that cycle.
- Reset asserted mid-settle or mid-pulse: all state returns to reset values immediately. No pulse is emitted after deassertion until a fresh commit.
- A digit re-scanned with an identical pattern after a blanking gap commits again. This is idempotent for value and valid, but it sets the seen bit.

Decomposition:
- Shared package sonar_display_pkg holds:
  - the 16-entry glyph constant array shared with the forward decoders;
  - SEG_BLANK = 7'h7F;
  - the FSM state typedef {SETTLING, HELD}.
- One sub-module, seven_segment_pattern_encoder, is combinational. It maps a 7-bit pattern to {is_hex, is_blank, nibble[3:0]}.

Test Plan:
- Reset: assert reset mid-run with digit 2 settling → all outputs 0 immediately; no pulse after release.
- Single digit commit: dig_sel=0001, seg_in=0110000 held 10 cycles → value_out[3:0]=3, digit_valid=0001 exactly STABLE_CYCLES+2 edges after capture.
- Glitch: seg_in toggles away for 1 cycle at count 5 → no commit until 8 further stable samples.
- Illegal and blank:
  - pattern 0110110 on digit 1 → digit_valid[1]=0, nibble unchanged, one err_illegal pulse;
  - 1111111 → valid cleared, no pulse.
- Full frame: scan digits 0..3 with glyphs 1,A,b,F and zero-sel gaps → value_out=16'hFbA1 (nibbles F,b,A,1), digit_valid=1111, one frame_done pulse; dig_sel=0011 commits nothing.
- clear coincident with a commit edge → outputs 0, no pulses, seen mask empty.
